// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// placed between the memory controller's memory-side port and external memory.
module data_cache #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int NUM_LINES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_read_valid,
  input  logic [ADDR_BITS-1:0] req_read_address,
  output logic                 req_read_ready,
  output logic [DATA_BITS-1:0] req_read_data,
  input  logic                 req_write_valid,
  input  logic [ADDR_BITS-1:0] req_write_address,
  input  logic [DATA_BITS-1:0] req_write_data,
  output logic                 req_write_ready,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  input  logic                 flush,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);
  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  typedef enum logic [2:0] {IDLE, FILL, WRITE, RESP, DRAIN} state_t;
  state_t state, state_next;

  logic [NUM_LINES-1:0]                line_valid;
  logic [NUM_LINES-1:0][TAG_BITS-1:0]  line_tag;
  logic [NUM_LINES-1:0][DATA_BITS-1:0] line_data;
  logic                                flush_pending;
  logic                                serve_read;

  logic [INDEX_BITS-1:0] rd_index, fill_index, wr_index;
  logic [TAG_BITS-1:0]   rd_tag, fill_tag, wr_tag;
  logic                  rd_hit, write_hit, do_flush, fill_done, write_done;

  // Fill and write-through use the latched downstream address, not the live request.
  assign rd_index   = req_read_address[INDEX_BITS-1:0];
  assign rd_tag     = req_read_address[ADDR_BITS-1:INDEX_BITS];
  assign fill_index = mem_read_address[INDEX_BITS-1:0];
  assign fill_tag   = mem_read_address[ADDR_BITS-1:INDEX_BITS];
  assign wr_index   = mem_write_address[INDEX_BITS-1:0];
  assign wr_tag     = mem_write_address[ADDR_BITS-1:INDEX_BITS];

  assign rd_hit     = line_valid[rd_index] && (line_tag[rd_index] == rd_tag);
  assign write_hit  = line_valid[wr_index] && (line_tag[wr_index] == wr_tag);
  assign do_flush   = flush_pending | flush;
  assign fill_done  = (state == FILL)  && mem_read_ready;
  assign write_done = (state == WRITE) && mem_write_ready;

  assign req_read_ready  = (state == RESP) &&  serve_read;
  assign req_write_ready = (state == RESP) && !serve_read;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!do_flush) begin
          if (req_read_valid)       state_next = rd_hit ? RESP : FILL;
          else if (req_write_valid) state_next = WRITE;
        end
      end
      FILL:    if (mem_read_ready)  state_next = RESP;
      WRITE:   if (mem_write_ready) state_next = RESP;
      RESP:    state_next = DRAIN;
      DRAIN:   if (!req_read_valid && !req_write_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid        <= '0;
      flush_pending     <= 1'b0;
      serve_read        <= 1'b0;
      req_read_data     <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      hit_count         <= '0;
      miss_count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_flush) begin
            line_valid    <= '0;
            flush_pending <= 1'b0;
          end else if (req_read_valid) begin
            serve_read <= 1'b1;
            if (rd_hit) begin
              req_read_data <= line_data[rd_index];
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= req_read_address;
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
          end else if (req_write_valid) begin
            serve_read        <= 1'b0;
            mem_write_valid   <= 1'b1;
            mem_write_address <= req_write_address;
            mem_write_data    <= req_write_data;
          end
        end
        FILL: begin
          if (mem_read_ready) begin
            mem_read_valid         <= 1'b0;
            line_valid[fill_index] <= 1'b1;
            req_read_data          <= mem_read_data;
          end
        end
        WRITE:   if (mem_write_ready) mem_write_valid <= 1'b0;
        default: ;
      endcase
      // A flush seen while busy is deferred to the next idle cycle.
      if (flush && (state != IDLE)) flush_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_done) begin
        line_tag[fill_index]  <= fill_tag;
        line_data[fill_index] <= mem_read_data;
      end else if (write_done && write_hit) begin
        line_data[wr_index] <= mem_write_data;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, hand-written corner
// sequences, then random traffic checked against a behavioural cache/memory model.
module tb_data_cache;
  logic        clk, reset;
  logic        req_read_valid, req_read_ready;
  logic [7:0]  req_read_address;
  logic [15:0] req_read_data;
  logic        req_write_valid, req_write_ready;
  logic [7:0]  req_write_address;
  logic [15:0] req_write_data;
  logic        mem_read_valid, mem_read_ready;
  logic [7:0]  mem_read_address;
  logic [15:0] mem_read_data;
  logic        mem_write_valid, mem_write_ready;
  logic [7:0]  mem_write_address;
  logic [15:0] mem_write_data;
  logic        flush;
  logic [15:0] hit_count, miss_count;

  data_cache #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_LINES(16)) dut (
    .clk(clk), .reset(reset),
    .req_read_valid(req_read_valid), .req_read_address(req_read_address),
    .req_read_ready(req_read_ready), .req_read_data(req_read_data),
    .req_write_valid(req_write_valid), .req_write_address(req_write_address),
    .req_write_data(req_write_data), .req_write_ready(req_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory (written only by the DUT) and the bench's own view of memory.
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  int lat = 3;
  int rd_wait = 0, wr_wait = 0;
  int mem_reads = 0, mem_writes = 0, rd_busy = 0, both_hi = 0;

  // Cache model: which full address each line holds, if any.
  bit         m_valid [16];
  logic [7:0] m_addr  [16];
  int exp_hits = 0, exp_misses = 0;

  int checks = 0, failures = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [15:0] wd;
    logic [15:0] ed;
    bit          eh;
  } vec_t;
  vec_t tbl [11];

  initial begin
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    forever begin
      @(negedge clk);
      mem_read_ready = 1'b0; mem_write_ready = 1'b0;
      if (mem_read_valid === 1'b1 && mem_write_valid === 1'b1) both_hi++;
      if (mem_read_valid === 1'b1) begin
        rd_busy++;
        if (rd_wait >= lat) begin
          mem_read_ready = 1'b1; mem_read_data = mem[mem_read_address];
          mem_reads++; rd_wait = 0;
        end else rd_wait++;
      end else rd_wait = 0;
      if (mem_write_valid === 1'b1) begin
        if (wr_wait >= lat) begin
          mem_write_ready = 1'b1; mem[mem_write_address] = mem_write_data;
          mem_writes++; wr_wait = 0;
        end else wr_wait++;
      end else wr_wait = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input bit is_wr, output int cyc, output bit ok);
    ok = 1'b0; cyc = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (is_wr ? req_write_ready : req_read_ready) ok = 1'b1;
    end
  endtask

  task automatic run_op(input bit is_wr, input logic [7:0] a, input logic [15:0] wd,
                        input logic [15:0] ed, input bit eh, input string nm);
    int cyc, r0, w0, b0;
    bit ok;
    @(negedge clk);
    r0 = mem_reads; w0 = mem_writes; b0 = rd_busy;
    if (is_wr) begin
      req_write_valid = 1'b1; req_write_address = a; req_write_data = wd;
      ref_mem[a] = wd;
    end else begin
      req_read_valid = 1'b1; req_read_address = a;
    end
    wait_ready(is_wr, cyc, ok);
    chk({nm, "_done"}, 32'(ok), 32'd1);
    req_read_valid = 1'b0; req_write_valid = 1'b0;
    if (is_wr) begin
      chk({nm, "_memwr"}, mem_writes - w0, 1);
      chk({nm, "_memdata"}, 32'(mem[a]), 32'(wd));
      chk({nm, "_nomemrd"}, rd_busy - b0, 0);
    end else begin
      if (eh) exp_hits++; else exp_misses++;
      chk({nm, "_data"}, 32'(req_read_data), 32'(ed));
      if (eh) begin
        chk({nm, "_nomemrd"}, rd_busy - b0, 0);
        chk({nm, "_lat"}, cyc, 1);
      end else chk({nm, "_memrd"}, mem_reads - r0, 1);
    end
    chk({nm, "_hits"}, 32'(hit_count), exp_hits);
    chk({nm, "_miss"}, 32'(miss_count), exp_misses);
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(req_read_ready | req_write_ready), 0);
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_read_valid = 1'b0; req_write_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    exp_hits = 0; exp_misses = 0;
  endtask

  initial begin
    int cyc, r0, w0, pulses;
    bit ok;
    logic [7:0] a;
    logic [3:0] idx;
    bit eh;

    tbl[0]  = '{1'b0, 8'h23, 16'h0000, 16'h1234, 1'b0};
    tbl[1]  = '{1'b0, 8'h23, 16'h0000, 16'h1234, 1'b1};
    tbl[2]  = '{1'b0, 8'h13, 16'h0000, 16'hBEEF, 1'b0};
    tbl[3]  = '{1'b0, 8'h23, 16'h0000, 16'h1234, 1'b0};
    tbl[4]  = '{1'b1, 8'h23, 16'h5555, 16'h0000, 1'b0};
    tbl[5]  = '{1'b0, 8'h23, 16'h0000, 16'h5555, 1'b1};
    tbl[6]  = '{1'b1, 8'h40, 16'h0A0A, 16'h0000, 1'b0};
    tbl[7]  = '{1'b0, 8'h40, 16'h0000, 16'h0A0A, 1'b0};
    tbl[8]  = '{1'b1, 8'h33, 16'h7777, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, 8'h23, 16'h0000, 16'h5555, 1'b1};
    tbl[10] = '{1'b0, 8'h33, 16'h0000, 16'h7777, 1'b0};

    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'hA5A5;
    mem[8'h23] = 16'h1234;
    mem[8'h13] = 16'hBEEF;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    reset = 1'b1; flush = 1'b0;
    req_read_valid = 1'b0; req_read_address = '0;
    req_write_valid = 1'b0; req_write_address = '0; req_write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_ready", 32'(req_read_ready), 0);
    chk("rst_wr_ready", 32'(req_write_ready), 0);
    chk("rst_mem_rd_valid", 32'(mem_read_valid), 0);
    chk("rst_mem_wr_valid", 32'(mem_write_valid), 0);
    chk("rst_rd_data", 32'(req_read_data), 0);
    chk("rst_hits", 32'(hit_count), 0);
    chk("rst_miss", 32'(miss_count), 0);
    reset = 1'b0;

    lat = 3;
    for (int i = 0; i < 11; i++)
      run_op(tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].ed, tbl[i].eh, $sformatf("vec%0d", i));

    // Flush while idle: the line holding 0x33 must be forgotten.
    pulse_flush();
    run_op(1'b0, 8'h33, 16'h0, 16'h7777, 1'b0, "flush_idle");

    // Simultaneous read and write: the read goes first, no memory write meanwhile.
    @(negedge clk);
    w0 = mem_writes;
    req_read_valid = 1'b1; req_read_address = 8'h23;
    req_write_valid = 1'b1; req_write_address = 8'h30; req_write_data = 16'h3030;
    wait_ready(1'b0, cyc, ok);
    chk("simul_rd_done", 32'(ok), 1);
    chk("simul_rd_data", 32'(req_read_data), 32'(ref_mem[8'h23]));
    chk("simul_no_wr_yet", mem_writes - w0, 0);
    exp_misses++;
    chk("simul_miss", 32'(miss_count), exp_misses);
    req_read_valid = 1'b0; req_write_valid = 1'b0;
    @(negedge clk);
    run_op(1'b1, 8'h30, 16'h3030, 16'h0, 1'b0, "simul_wr");

    // Flush during a fill: the fill still responds, the line is then invalid.
    lat = 5;
    @(negedge clk);
    req_read_valid = 1'b1; req_read_address = 8'h50;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    wait_ready(1'b0, cyc, ok);
    chk("ffill_done", 32'(ok), 1);
    chk("ffill_data", 32'(req_read_data), 32'(ref_mem[8'h50]));
    exp_misses++;
    chk("ffill_miss", 32'(miss_count), exp_misses);
    req_read_valid = 1'b0;
    @(negedge clk);
    run_op(1'b0, 8'h50, 16'h0, ref_mem[8'h50], 1'b0, "ffill_reread");

    // Reset in the middle of a fill abandons it with no response.
    lat = 8;
    @(negedge clk);
    req_read_valid = 1'b1; req_read_address = 8'h60;
    repeat (2) @(negedge clk);
    chk("rfill_busy", 32'(mem_read_valid), 1);
    reset = 1'b1; req_read_valid = 1'b0;
    @(negedge clk);
    chk("rfill_mem_rd_valid", 32'(mem_read_valid), 0);
    chk("rfill_hits", 32'(hit_count), 0);
    chk("rfill_miss", 32'(miss_count), 0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_read_ready) pulses++;
      @(negedge clk);
    end
    chk("rfill_no_pulse", pulses, 0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    exp_hits = 0; exp_misses = 0;

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      lat = $urandom_range(0, 3);
      a = 8'($urandom_range(0, 47));
      idx = a[3:0];
      if ($urandom_range(0, 19) == 0) pulse_flush();
      if ($urandom_range(0, 2) == 0) begin
        run_op(1'b1, a, 16'($urandom), 16'h0, 1'b0, "rnd_wr");
      end else begin
        eh = m_valid[idx] && (m_addr[idx] == a);
        if (!eh) begin m_valid[idx] = 1'b1; m_addr[idx] = a; end
        run_op(1'b0, a, 16'h0, ref_mem[a], eh, "rnd_rd");
      end
    end

    chk("mem_valid_exclusive", both_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Small direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
- Sits between the memory controller's memory-side port and external data memory.
- Upstream side presents the same valid/ready read/write interface the controller already drives; downstream side presents that same interface to memory.
- Cuts repeated-read traffic and provides hit/miss counters for kernel profiling.

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 16, data word width.
- NUM_LINES, 16, number of lines; power of two, >=2. INDEX_BITS = clog2(NUM_LINES), TAG_BITS = ADDR_BITS - INDEX_BITS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_read_valid  input  1  upstream read request, held until req_read_ready.
- req_read_address  input  ADDR_BITS  read address.
- req_read_ready  output  1  one-cycle pulse: read complete, req_read_data valid.
- req_read_data  output  DATA_BITS  read data; holds last value until next read response.
- req_write_valid  input  1  upstream write request, held until req_write_ready.
- req_write_address  input  ADDR_BITS  write address.
- req_write_data  input  DATA_BITS  write data.
- req_write_ready  output  1  one-cycle pulse: write accepted by memory.
- mem_read_valid  output  1  downstream read request.
- mem_read_address  output  ADDR_BITS  downstream read address.
- mem_read_ready  input  1  memory read done; mem_read_data valid this cycle.
- mem_read_data  input  DATA_BITS  memory read data.
- mem_write_valid  output  1  downstream write request.
- mem_write_address  output  ADDR_BITS  downstream write address.
- mem_write_data  output  DATA_BITS  downstream write data.
- mem_write_ready  input  1  memory write done.
- flush  input  1  pulse: invalidate all lines.
- hit_count  output  16  saturating read-hit counter.
- miss_count  output  16  saturating read-miss counter.

Behaviour:
- Address split: index = addr[INDEX_BITS-1:0], tag = addr[ADDR_BITS-1:INDEX_BITS].
- Storage per line: valid bit, tag, data.
- Reset:
  - All outputs 0; all valid bits 0; counters 0; state IDLE; flush_pending 0.
  - Tag/data arrays need no reset.
  - Reset mid-transaction abandons it immediately; no response pulse is issued.
- States: IDLE, FILL, WRITE, RESP, DRAIN.
- IDLE:
  - If flush_pending or flush: clear all valid bits, clear flush_pending, accept no request this cycle.
  - Else if req_read_valid (read has priority over a simultaneous write):
    - Hit (valid & tag match): register line data to req_read_data, hit_count++, go RESP. Latency: ready pulses the cycle after valid is first seen.
    - Miss: mem_read_valid<=1, mem_read_address<=req addr, miss_count++, go FILL.
  - Else if req_write_valid: mem_write_valid<=1, drive address/data from the request, go WRITE.
- FILL:
  - Hold mem_read_valid until mem_read_ready.
  - On ready: mem_read_valid<=0; write data/tag into the line and set valid; req_read_data<=mem_read_data; go RESP.
- WRITE:
  - Hold mem_write_valid until mem_write_ready.
  - On ready: mem_write_valid<=0. If the line holds the same tag and is valid, update its data (write-through); otherwise leave the line untouched (no allocate). Go RESP.
- RESP:
  - Assert req_read_ready or req_write_ready (matching the served request) for exactly one cycle, then go DRAIN.
- DRAIN:
  - Wait until req_read_valid and req_write_valid are both 0, then go IDLE.
  - Prevents re-serving a held request.
- flush outside IDLE: set flush_pending; it is applied on the next IDLE cycle.
- A fill completing in the same cycle as a flush still writes its line; the pending flush then invalidates it.
- Counters saturate at 0xFFFF; writes do not count.
- mem_read_valid and mem_write_valid are never both high. Upstream inputs are sampled only in IDLE; changes to request address/data after acceptance are ignored.

Test Plan:
- Cold read: after reset, read addr 0x23, memory returns 0x1234 after 3 cycles -> one mem read of 0x23, req_read_ready pulse with data 0x1234, miss_count=1.
- Re-read 0x23 -> no mem_read_valid, req_read_ready the cycle after valid, data 0x1234, hit_count=1.
- Conflict: read 0x13 (same index 3, NUM_LINES=16) returns 0xBEEF, then read 0x23 -> two misses, 0x23 refetched from memory.
- Write 0x23=0x5555 while line holds 0x23 -> mem write issued, req_write_ready pulses once; next read 0x23 hits with 0x5555. Write 0x40 (not cached), then read 0x40 -> miss.
- Simultaneous read 0x23 and write 0x30 valid -> read served first; write served after read valid drops and DRAIN completes.
- flush pulsed during FILL of 0x50 -> fill completes and responds; next read 0x50 misses. Reset asserted mid-FILL -> mem_read_valid 0 next cycle, no ready pulse, counters 0.
